// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the F/D/E/M datapath: load-use bubbles, redirect flushes and memory-wait freezes.
// Optional build macro HAZARD_STATS_EN adds stallCount/flushCount/waitCount event counters.
module pipeline_hazard_ctrl #(
  parameter int REGBITS      = 4,
  parameter int TIMEOUT_BITS = 8,
  parameter int MEM_TIMEOUT  = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGBITS-1:0] src1Index_D,
  input  logic [REGBITS-1:0] src2Index_D,
  input  logic               useSrc1_D,
  input  logic               useSrc2_D,
  input  logic [REGBITS-1:0] destIndex_E,
  input  logic               memRead_E,
  input  logic               regWrtEn_E,
  input  logic               noop_E,
  input  logic               redirect_E,
  input  logic               memReq_M,
  input  logic               memReady_M,
  output logic               pc_wrtEn,
  output logic               fd_wrtEn,
  output logic               fd_noop,
  output logic               de_wrtEn,
  output logic               de_noop,
  output logic               em_wrtEn,
  output logic               mem_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stallCount,
  output logic [31:0]        flushCount,
  output logic [31:0]        waitCount
`endif
);

  localparam logic [1:0] INIT     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] ERROR    = 2'd3;

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [TIMEOUT_BITS-1:0] wait_cnt;
  logic                    load_use;
  logic                    mem_busy;
  logic                    advance;
  logic                    timeout;
  logic                    err_q;

  assign load_use = memRead_E & regWrtEn_E & ~noop_E &
                    ((useSrc1_D & (src1Index_D == destIndex_E)) |
                     (useSrc2_D & (src2Index_D == destIndex_E)));
  assign mem_busy = memReq_M & ~memReady_M;
  assign timeout  = (wait_cnt == TIMEOUT_BITS'(MEM_TIMEOUT));
  assign mem_err  = err_q;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    pc_wrtEn   = 1'b0;
    fd_wrtEn   = 1'b0;
    fd_noop    = 1'b0;
    de_wrtEn   = 1'b0;
    de_noop    = 1'b0;
    em_wrtEn   = 1'b0;
    case (state)
      INIT: begin
        pc_wrtEn   = 1'b1;
        fd_wrtEn   = 1'b1;
        de_wrtEn   = 1'b1;
        em_wrtEn   = 1'b1;
        fd_noop    = 1'b1;
        de_noop    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (mem_busy) state_next = MEM_WAIT;
        else          advance    = 1'b1;
      end
      MEM_WAIT: begin
        if (memReady_M) begin
          advance    = 1'b1;
          state_next = RUN;
        end else if (timeout) begin
          state_next = ERROR;
        end
      end
      default: ;
    endcase

    // Redirect outranks load-use: the dependent D instruction is squashed anyway.
    if (advance) begin
      if (redirect_E) begin
        pc_wrtEn = 1'b1;
        fd_wrtEn = 1'b1;
        de_wrtEn = 1'b1;
        em_wrtEn = 1'b1;
        fd_noop  = 1'b1;
        de_noop  = 1'b1;
      end else if (load_use) begin
        de_wrtEn = 1'b1;
        em_wrtEn = 1'b1;
        de_noop  = 1'b1;
      end else begin
        pc_wrtEn = 1'b1;
        fd_wrtEn = 1'b1;
        de_wrtEn = 1'b1;
        em_wrtEn = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        RUN: if (mem_busy) wait_cnt <= TIMEOUT_BITS'(1);
        MEM_WAIT: begin
          if (memReady_M)          wait_cnt <= '0;
          else if (wait_cnt != '1) wait_cnt <= wait_cnt + TIMEOUT_BITS'(1);
        end
        default: ;
      endcase
      if (state_next == ERROR) err_q <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
      flushCount <= '0;
      waitCount  <= '0;
    end else begin
      if (advance & ~redirect_E & load_use) stallCount <= stallCount + 32'd1;
      if (advance & redirect_E)             flushCount <= flushCount + 32'd1;
      if (state == MEM_WAIT)                waitCount  <= waitCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues hand-computed expected controls per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] dst;
    logic       mrd;
    logic       rwe;
    logic       nop;
    logic       rdr;
    logic       mrq;
    logic       mry;
  } in_t;

  // Expected output word: {pc_wrtEn, fd_wrtEn, fd_noop, de_wrtEn, de_noop, em_wrtEn, mem_err}
  localparam logic [6:0] E_INIT   = 7'b1111110;
  localparam logic [6:0] E_RUN    = 7'b1101010;
  localparam logic [6:0] E_STALL  = 7'b0001110;
  localparam logic [6:0] E_FLUSH  = 7'b1111110;
  localparam logic [6:0] E_FREEZE = 7'b0000000;
  localparam logic [6:0] E_ERROR  = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] src1Index_D = '0, src2Index_D = '0, destIndex_E = '0;
  logic       useSrc1_D = 1'b0, useSrc2_D = 1'b0, memRead_E = 1'b0, regWrtEn_E = 1'b0;
  logic       noop_E = 1'b0, redirect_E = 1'b0, memReq_M = 1'b0, memReady_M = 1'b0;
  logic       pc_wrtEn, fd_wrtEn, fd_noop, de_wrtEn, de_noop, em_wrtEn, mem_err;
`ifdef HAZARD_STATS_EN
  logic [31:0] stallCount, flushCount, waitCount;
`endif

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REGBITS(4), .TIMEOUT_BITS(8), .MEM_TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .src1Index_D(src1Index_D), .src2Index_D(src2Index_D),
    .useSrc1_D(useSrc1_D), .useSrc2_D(useSrc2_D),
    .destIndex_E(destIndex_E), .memRead_E(memRead_E), .regWrtEn_E(regWrtEn_E),
    .noop_E(noop_E), .redirect_E(redirect_E),
    .memReq_M(memReq_M), .memReady_M(memReady_M),
    .pc_wrtEn(pc_wrtEn), .fd_wrtEn(fd_wrtEn), .fd_noop(fd_noop),
    .de_wrtEn(de_wrtEn), .de_noop(de_noop), .em_wrtEn(em_wrtEn),
    .mem_err(mem_err)
`ifdef HAZARD_STATS_EN
    , .stallCount(stallCount), .flushCount(flushCount), .waitCount(waitCount)
`endif
  );

  // Monitor: one expected word is consumed per cycle in which the driver issued a vector.
  always @(negedge clk) begin
    logic [6:0] got;
    logic [6:0] exp;
    string      nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_wrtEn, fd_wrtEn, fd_noop, de_wrtEn, de_noop, em_wrtEn, mem_err};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b (pc fd fdn de den em err)", nm, got, exp);
      end
    end
  end

  task automatic apply(input in_t v, input logic [6:0] exp, input string nm);
    @(posedge clk);
    #1;
    reset       = v.rst;
    src1Index_D = v.s1;
    src2Index_D = v.s2;
    useSrc1_D   = v.u1;
    useSrc2_D   = v.u2;
    destIndex_E = v.dst;
    memRead_E   = v.mrd;
    regWrtEn_E  = v.rwe;
    noop_E      = v.nop;
    redirect_E  = v.rdr;
    memReq_M    = v.mrq;
    memReady_M  = v.mry;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  initial begin
    in_t idle, lu, v;
    idle = '0;
    idle.rst = 1'b1;
    // Load in E writing r5, D reads r5 through src2.
    lu = idle;
    lu.mrd = 1'b1; lu.rwe = 1'b1; lu.dst = 4'd5; lu.s2 = 4'd5; lu.u2 = 1'b1; lu.s1 = 4'd2;

    // Reset low for three cycles, then one INIT drain cycle, then RUN.
    v = idle; v.rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(v, E_INIT, "reset_held");
    apply(idle, E_INIT, "init_drain");
    apply(idle, E_RUN, "run_idle");

    // Load-use: exactly one bubble, then the load has left E.
    apply(lu, E_STALL, "load_use_src2");
    v = lu; v.nop = 1'b1;
    apply(v, E_RUN, "after_bubble");
    v = lu; v.nop = 1'b1;
    apply(v, E_RUN, "noop_E_masks");
    v = lu; v.u2 = 1'b0;
    apply(v, E_RUN, "src2_unused");
    v = lu; v.rwe = 1'b0;
    apply(v, E_RUN, "no_regwrite");
    v = lu; v.dst = 4'd6;
    apply(v, E_RUN, "index_mismatch");
    v = lu; v.u2 = 1'b0; v.s1 = 4'd5; v.u1 = 1'b1;
    apply(v, E_STALL, "load_use_src1");
    apply(idle, E_RUN, "idle_again");

    // Redirect together with load-use: flush wins, no bubble afterwards.
    v = lu; v.rdr = 1'b1;
    apply(v, E_FLUSH, "redirect_over_lu");
    apply(idle, E_RUN, "no_bubble_after_flush");

    // Four freeze cycles, redirect kept and serviced on the release cycle.
    v = idle; v.mrq = 1'b1; v.rdr = 1'b1;
    for (int i = 0; i < 4; i++) apply(v, E_FREEZE, "mem_freeze");
    v.mry = 1'b1;
    apply(v, E_FLUSH, "release_redirect");
    apply(idle, E_RUN, "run_after_release");

    // Load-use pending across a one-cycle freeze becomes a bubble on release.
    v = lu; v.mrq = 1'b1;
    apply(v, E_FREEZE, "freeze_with_lu");
    v.mry = 1'b1;
    apply(v, E_STALL, "release_load_use");
    apply(idle, E_RUN, "run_after_lu");

    // Timeout: entry cycle plus 10 MEM_WAIT cycles frozen, then sticky ERROR.
    v = idle; v.mrq = 1'b1; v.rdr = 1'b1;
    apply(v, E_FREEZE, "wait_entry");
    for (int i = 0; i < 10; i++) apply(v, E_FREEZE, "wait_no_err");
    apply(v, E_ERROR, "timeout_error");
    v.mry = 1'b1;
    apply(v, E_ERROR, "error_ignores_ready");
    apply(idle, E_ERROR, "error_sticky");
    apply(idle, E_ERROR, "error_sticky2");

    // Asynchronous reset clears ERROR immediately.
    v = idle; v.rst = 1'b0;
    apply(v, E_INIT, "async_reset");
    apply(idle, E_INIT, "init_after_err");
    apply(idle, E_RUN, "run_after_err");

    // Async reset in the middle of a freeze discards it.
    v = idle; v.mrq = 1'b1;
    apply(v, E_FREEZE, "freeze_pre_reset");
    v.rst = 1'b0;
    apply(v, E_INIT, "reset_mid_wait");
    apply(idle, E_INIT, "init_again");
    apply(idle, E_RUN, "run_final");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
